rx_fifo: RTL

RX_FIFO -- requirements
Module: rx_fifo

---
 rtl/rx_fifo.sv | 109 ++++++++++
 1 files changed

// File: rtl/rx_fifo.sv
// UART receive FIFO: edge-detected rx_done writes, rd_en reads with 1-clk registered dout/dout_valid.
// No backpressure to the receiver: writes into a full FIFO are dropped and flagged in sticky overflow.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_done,
    input  logic             rd_en,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             done_q;

    logic wr;
    logic wr_acc;
    logic rd_acc;
    logic drop;

    // Flags come straight from the registered count so they track it in the same cycle.
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    always_comb begin
        wr     = rx_done & ~done_q;
        rd_acc = rd_en & ~empty;
        // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
        wr_acc = wr & (~full | rd_acc);
        drop   = wr & full & ~rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= rx_done;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_acc;
            if (rd_acc) begin
                dout <= mem[rd_ptr];
            end
        end
    end

    // A fresh drop wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
